// File: rtl/etapa_decodificacion.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : etapa_decodificacion                                         |
// | Description : MIPS instruction-decode stage with integrated 32-entry       |
// |               register file and ID/EX pipeline register. Decodes one       |
// |               instruction per cycle into the ALU function code and its two |
// |               operands.                                                    |
// | Ports       : clk, reset (async, active-high)                              |
// |               instr_in/valid_in   - instruction from IF/ID (0 = bubble)    |
// |               stall/flush         - ID/EX hold / bubble (flush wins)       |
// |               wb_en/wb_reg/wb_data - register-file write-back port         |
// |               Operando1/Operando2/Instruccion - registered ALU interface   |
// |               reg_dest/reg_write  - registered destination info            |
// |               valid_out           - ID/EX holds a real instruction         |
// |               ilegal              - one-cycle unsupported-instruction pulse|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module etapa_decodificacion #(
    parameter int bits = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr_in,
    input  logic            valid_in,
    input  logic            stall,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_reg,
    input  logic [bits-1:0] wb_data,
    output logic [bits-1:0] Operando1,
    output logic [bits-1:0] Operando2,
    output logic [5:0]      Instruccion,
    output logic [4:0]      reg_dest,
    output logic            reg_write,
    output logic            valid_out,
    output logic            ilegal
);

    // Opcodes
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_addiu = 6'b001001;
    localparam logic [5:0] c_op_sltiu = 6'b001011;
    localparam logic [5:0] c_op_andi  = 6'b001100;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_xori  = 6'b001110;
    localparam logic [5:0] c_op_lui   = 6'b001111;

    // ALU function codes (identical to the R-type funct values)
    localparam logic [5:0] c_fn_addu  = 6'b100001;
    localparam logic [5:0] c_fn_subu  = 6'b100011;
    localparam logic [5:0] c_fn_and   = 6'b100100;
    localparam logic [5:0] c_fn_or    = 6'b100101;
    localparam logic [5:0] c_fn_xor   = 6'b100110;
    localparam logic [5:0] c_fn_nor   = 6'b100111;
    localparam logic [5:0] c_fn_sltu  = 6'b101011;

    // Instruction fields
    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [15:0] w_imm;
    logic [5:0]  w_funct;
    logic        w_unused;

    assign w_op     = instr_in[31:26];
    assign w_rs     = instr_in[25:21];
    assign w_rt     = instr_in[20:16];
    assign w_rd     = instr_in[15:11];
    assign w_imm    = instr_in[15:0];
    assign w_funct  = instr_in[5:0];
    // shamt is not used by any supported instruction
    assign w_unused = ^instr_in[10:6];

    // ------------------------------------------------------------------------
    // Register file. Entry 0 is never written, and reads of index 0 are forced
    // to zero anyway. Write-through makes a same-cycle write visible to decode.
    // ------------------------------------------------------------------------
    logic [bits-1:0] r_regs [32];
    logic [bits-1:0] w_rs_val;
    logic [bits-1:0] w_rt_val;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_en && (wb_reg != 5'd0)) begin
            r_regs[wb_reg] <= wb_data;
        end
    end

    always_comb begin
        w_rs_val = '0;
        if (w_rs != 5'd0) begin
            if (wb_en && (wb_reg == w_rs)) begin
                w_rs_val = wb_data;
            end else begin
                w_rs_val = r_regs[w_rs];
            end
        end
    end

    always_comb begin
        w_rt_val = '0;
        if (w_rt != 5'd0) begin
            if (wb_en && (wb_reg == w_rt)) begin
                w_rt_val = wb_data;
            end else begin
                w_rt_val = r_regs[w_rt];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    logic            w_legal;
    logic [5:0]      w_fn;
    logic [bits-1:0] w_op1;
    logic [bits-1:0] w_op2;
    logic [4:0]      w_dest;
    logic [bits-1:0] w_imm_sx;
    logic [bits-1:0] w_imm_zx;
    logic [bits-1:0] w_imm_hi;

    assign w_imm_sx = {{(bits-16){w_imm[15]}}, w_imm};
    assign w_imm_zx = {{(bits-16){1'b0}}, w_imm};

    always_comb begin
        w_imm_hi        = '0;
        w_imm_hi[31:16] = w_imm;
    end

    always_comb begin
        w_legal = 1'b0;
        w_fn    = 6'b000000;
        w_op1   = w_rs_val;
        w_op2   = w_rt_val;
        w_dest  = w_rt;
        case (w_op)
            c_op_rtype: begin
                w_dest = w_rd;
                case (w_funct)
                    c_fn_addu, c_fn_subu, c_fn_and, c_fn_or,
                    c_fn_xor, c_fn_nor, c_fn_sltu: begin
                        w_legal = 1'b1;
                        w_fn    = w_funct;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            c_op_addiu: begin
                w_legal = 1'b1;
                w_fn    = c_fn_addu;
                w_op2   = w_imm_sx;
            end
            c_op_sltiu: begin
                w_legal = 1'b1;
                w_fn    = c_fn_sltu;
                w_op2   = w_imm_sx;
            end
            c_op_andi: begin
                w_legal = 1'b1;
                w_fn    = c_fn_and;
                w_op2   = w_imm_zx;
            end
            c_op_ori: begin
                w_legal = 1'b1;
                w_fn    = c_fn_or;
                w_op2   = w_imm_zx;
            end
            c_op_xori: begin
                w_legal = 1'b1;
                w_fn    = c_fn_xor;
                w_op2   = w_imm_zx;
            end
            c_op_lui: begin
                // Executed on the ALU as 0 OR (imm << 16)
                w_legal = 1'b1;
                w_fn    = c_fn_or;
                w_op1   = '0;
                w_op2   = w_imm_hi;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // ID/EX pipeline register. flush beats stall; a stall holds the operands
    // but never re-issues the ilegal pulse.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Operando1   <= '0;
            Operando2   <= '0;
            Instruccion <= 6'b000000;
            reg_dest    <= 5'd0;
            reg_write   <= 1'b0;
            valid_out   <= 1'b0;
            ilegal      <= 1'b0;
        end else if (flush) begin
            Operando1   <= '0;
            Operando2   <= '0;
            Instruccion <= 6'b000000;
            reg_dest    <= 5'd0;
            reg_write   <= 1'b0;
            valid_out   <= 1'b0;
            ilegal      <= 1'b0;
        end else if (stall) begin
            ilegal      <= 1'b0;
        end else if (!valid_in || !w_legal) begin
            Operando1   <= '0;
            Operando2   <= '0;
            Instruccion <= 6'b000000;
            reg_dest    <= 5'd0;
            reg_write   <= 1'b0;
            valid_out   <= 1'b0;
            ilegal      <= valid_in && !w_legal;
        end else begin
            Operando1   <= w_op1;
            Operando2   <= w_op2;
            Instruccion <= w_fn;
            reg_dest    <= w_dest;
            reg_write   <= (w_dest != 5'd0);
            valid_out   <= 1'b1;
            ilegal      <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/etapa_decodificacion.md
# etapa_decodificacion

Instruction-decode stage with integrated register file, sitting between instruction fetch and the ALU. It decodes one 32-bit MIPS instruction per cycle into the ALU's 6-bit function code and its two operands. It reads and writes a 32-entry register file and registers the result into the ID/EX pipeline register, with stall, flush and write-back support. It is the producer side of the ALU's Operando1/Operando2/Instruccion interface.

## Interface
- bits, 32: datapath width; must be ≥ 32.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears register file and all outputs.
- instr_in  in  32  instruction from IF/ID.
- valid_in  in  1  instr_in is a real instruction; 0 = bubble.
- stall  in  1  hold ID/EX register contents.
- flush  in  1  load a bubble into ID/EX; has priority over stall.
- wb_en  in  1  register-file write enable.
- wb_reg  in  5  write-back register index.
- wb_data  in  bits  write-back data.
- Operando1  out  bits  ALU operand 1 (registered).
- Operando2  out  bits  ALU operand 2 (registered).
- Instruccion  out  6  ALU function code (registered).
- reg_dest  out  5  destination register (registered).
- reg_write  out  1  destination is written at write-back (registered).
- valid_out  out  1  ID/EX holds a real instruction.
- ilegal  out  1  one-cycle pulse: the captured instruction was unsupported.

## Operation
- Fields: op=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0], funct=[5:0].
- R-type (op=000000): accepted funct values are ADDU 100001, SUBU 100011, AND 100100, OR 100101, XOR 100110, NOR 100111, SLTU 101011. For these: Instruccion=funct, Op1=R[rs], Op2=R[rt], dest=rd. Any other funct is illegal.
- I-type, all with dest=rt:
  - ADDIU 001001: Instruccion=100001, Op2 = sign-extended imm.
  - SLTIU 001011: Instruccion=101011, Op2 = sign-extended imm.
  - ANDI 001100: Instruccion=100100, Op2 = zero-extended imm.
  - ORI 001101: Instruccion=100101, Op2 = zero-extended imm.
  - XORI 001110: Instruccion=100110, Op2 = zero-extended imm.
  - In all of the above, Op1=R[rs].
  - LUI 001111: Instruccion=100101, Op1=0, Op2={imm,16'b0} zero-extended to bits.
- Any other op is illegal.
- reg_write = 1 for every legal instruction with dest≠0; dest=0 gives reg_write=0.
- Illegal instruction with valid_in=1: loads a bubble and pulses ilegal for 1 cycle.
- Bubble = valid_out=0, reg_write=0, Instruccion=000000, Operando1/2=0, reg_dest=0.
- Register file: 32×bits, R0 reads 0 always.
  - Write at rising edge when wb_en=1 and wb_reg≠0.
  - Reads are combinational with write-through: if wb_en and wb_reg==index≠0, the read returns wb_data.
- No hazard detection or forwarding from EX/MEM; the hazard unit handles that.

## Timing
- Reset (asynchronous): all outputs 0, all 32 registers 0, ilegal=0. The first capture is on the first rising edge after deassertion.
- Latency: 1 cycle from instr_in to the ID/EX outputs.
- Per-edge priority: flush → bubble; else stall → hold all outputs and force ilegal=0; else capture the decode (bubble if valid_in=0).
- Register-file writes occur regardless of stall or flush.
- Same-cycle write and read of the same register: the captured operand is the new wb_data.
- Reset asserted mid-stream: immediate clear, no completion of the in-flight capture.
- ilegal is high only in the cycle after an illegal capture, never during stall or flush.

## Test plan
- Reset, then write R1=5 and R2=3 via write-back, then ADDU $3,$1,$2 (0x00221821) → next cycle Operando1=5, Operando2=3, Instruccion=100001, reg_dest=3, reg_write=1, valid_out=1.
- ADDIU $4,$0,0xFFFF → Operando2=0xFFFFFFFF, Instruccion=100001; ANDI $4,$0,0xFFFF → Operando2=0x0000FFFF, Instruccion=100100; LUI $5,0x1234 → Operando1=0, Operando2=0x12340000, Instruccion=100101.
- Same-cycle bypass: wb_en=1, wb_reg=1, wb_data=0xA5 with SUBU $6,$1,$0 → Operando1=0xA5. Also write wb_reg=0 with data 7, then read R0 → 0.
- Funct 000000 with op=0, and op=100011 → bubble plus ilegal=1 for exactly one cycle each. ADDU with rd=0 → valid_out=1, reg_write=0.
- Stall for 3 cycles while instr_in changes → outputs constant. flush together with stall → bubble. valid_in=0 → bubble.
- Assert reset between clock edges after a valid capture → all outputs 0 immediately, and a subsequent read of R1 gives 0.
